// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32I core: ALU control codes, opcodes,
// immediate formats and the ID/EX register layout.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'h0,
    ALU_SUB      = 4'h1,
    ALU_SLL      = 4'h2,
    ALU_SLT      = 4'h3,
    ALU_SLTU     = 4'h4,
    ALU_XOR      = 4'h5,
    ALU_SRL      = 4'h6,
    ALU_SRA      = 4'h7,
    ALU_OR       = 4'h8,
    ALU_AND      = 4'h9,
    ALU_PASS_OP2 = 4'hA,
    ALU_PCADD4   = 4'hB
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U
  } imm_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic            reg_we;
    alu_ctrl_e       alu_ctrl;
    logic [4:0]      rd;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] pcadd4;
  } idex_t;

  // alt is the inst[30] qualifier; it only changes funct3 000 and 101.
  function automatic alu_ctrl_e funct3_ctrl(input logic [2:0] funct3, input logic alt);
    alu_ctrl_e c;
    case (funct3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] imm_expand(input logic [XLEN-1:0] inst, input imm_type_e sel);
    logic [XLEN-1:0] imm;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_U:   imm = {inst[31:12], 12'h000};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// ID/EX issue bundle: decode-side valid/ready and operands in, registered
// EX-side ALU view out. master is the issue stage, slave the surrounding core.
interface alu_op_issue_if;
  import alu_pkg::*;

  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  alu_ctrl_e       ex_alu_ctrl;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_pcadd4;
  logic [4:0]      ex_rd;
  logic            ex_reg_we;
  logic            ex_illegal;

  modport master (
    input  id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data, flush, ex_ready,
    output id_ready, ex_valid, ex_alu_ctrl, ex_op1, ex_op2, ex_pcadd4, ex_rd,
           ex_reg_we, ex_illegal
  );

  modport slave (
    output id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_alu_ctrl, ex_op1, ex_op2, ex_pcadd4, ex_rd,
           ex_reg_we, ex_illegal
  );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: instruction word to ALU control code, operand
// selection, writeback enable and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output alu_ctrl_e       ctrl_o,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic            reg_we_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  imm_type_e  imm_sel;
  logic       we_raw;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rd     = inst_i[11:7];

  always_comb begin
    ctrl_o    = ALU_ADD;
    op1_o     = rs1_i;
    imm_sel   = IMM_NONE;
    we_raw    = 1'b0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl_o    = funct3_ctrl(funct3, inst_i[30]);
        we_raw    = 1'b1;
        illegal_o = !((funct7 == F7_ZERO) ||
                      ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        // ADDI has no SUB form, so inst[30] only matters for the right shifts.
        ctrl_o  = funct3_ctrl(funct3, inst_i[30] && (funct3 == 3'b101));
        imm_sel = IMM_I;
        we_raw  = 1'b1;
        if (funct3 == 3'b001) begin
          illegal_o = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          illegal_o = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
        end
      end
      OPC_LUI: begin
        ctrl_o  = ALU_PASS_OP2;
        op1_o   = '0;
        imm_sel = IMM_U;
        we_raw  = 1'b1;
      end
      OPC_AUIPC: begin
        op1_o   = pc_i;
        imm_sel = IMM_U;
        we_raw  = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o = ALU_PCADD4;
        op1_o  = pc_i;
        we_raw = 1'b1;
      end
      OPC_JALR: begin
        ctrl_o    = ALU_PCADD4;
        imm_sel   = IMM_I;
        we_raw    = 1'b1;
        illegal_o = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        imm_sel = IMM_I;
        we_raw  = 1'b1;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
      end
      OPC_BRANCH: begin
        case (funct3[2:1])
          2'b00:   ctrl_o = ALU_SUB;
          2'b10:   ctrl_o = ALU_SLT;
          2'b11:   ctrl_o = ALU_SLTU;
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
    op2_o    = (imm_sel == IMM_NONE) ? rs2_i : imm_expand(inst_i, imm_sel);
    reg_we_o = we_raw && (rd != 5'd0) && !illegal_o;
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issue stage: decodes the ID beat and holds it in a one-entry register
// with valid/ready back-pressure and flush toward the EX-stage ALU.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_op_issue_if.master bus
);

  idex_t             ex_q;
  idex_t             ex_d;
  idex_t             issue;
  alu_ctrl_e         dec_ctrl;
  logic [DATA_W-1:0] dec_op1;
  logic [DATA_W-1:0] dec_op2;
  logic [DATA_W-1:0] pc_plus4;
  logic              dec_we;
  logic              dec_illegal;
  logic              id_ready;
  logic              load;

  alu_op_decode u_decode (
    .inst_i    (bus.id_inst),
    .pc_i      (bus.id_pc),
    .rs1_i     (bus.id_rs1_data),
    .rs2_i     (bus.id_rs2_data),
    .ctrl_o    (dec_ctrl),
    .op1_o     (dec_op1),
    .op2_o     (dec_op2),
    .reg_we_o  (dec_we),
    .illegal_o (dec_illegal)
  );

  assign pc_plus4 = bus.id_pc + DATA_W'(4);
  // A flush empties the register anyway, so the stage never stalls ID during one.
  assign id_ready = bus.flush || !ex_q.valid || bus.ex_ready;
  assign load     = bus.id_valid && id_ready && !bus.flush;

  always_comb begin
    issue.valid  = 1'b1;
    issue.rd     = bus.id_inst[11:7];
    issue.pcadd4 = pc_plus4;
    if (dec_illegal) begin
      issue.illegal  = ILLEGAL_AS_NOP;
      issue.reg_we   = 1'b0;
      issue.alu_ctrl = ALU_ADD;
      issue.op1      = '0;
      issue.op2      = '0;
    end else begin
      issue.illegal  = 1'b0;
      issue.reg_we   = dec_we;
      issue.alu_ctrl = dec_ctrl;
      issue.op1      = dec_op1;
      issue.op2      = dec_op2;
    end
  end

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (load) begin
      ex_d = issue;
    end else if (bus.ex_ready) begin
      ex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.id_ready    = id_ready;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_illegal  = ex_q.illegal;
  assign bus.ex_reg_we   = ex_q.reg_we;
  assign bus.ex_alu_ctrl = ex_q.alu_ctrl;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_op1      = ex_q.op1;
  assign bus.ex_op2      = ex_q.op2;
  assign bus.ex_pcadd4   = ex_q.pcadd4;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed vector table, back-pressure/flush/reset
// sequences and random traffic against an instruction-level reference model.
module tb_alu_op_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_op_issue_if bus ();

  alu_op_issue #(
    .DATA_W         (32),
    .ILLEGAL_AS_NOP (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic        ill;
    logic        we;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pcadd4;
  } expect_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vector_t;

  localparam logic [3:0] ALU_TAB [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
  localparam logic [3:0] BR_TAB  [8] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h3, 4'h3, 4'h4, 4'h4};
  localparam logic [6:0] OPC_LIST [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                          7'h67, 7'h03, 7'h23, 7'h63};

  int      vecCount  = 0;
  int      missCount = 0;
  expect_t model;
  vector_t vecs[$];

  // Instruction-level meaning of each RV32I form, straight from the ISA rules.
  function automatic expect_t refDecode(input logic [31:0] inst, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
    expect_t     e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic        we;
    logic [31:0] immI;
    logic [31:0] immS;
    logic [31:0] immU;
    f3    = inst[14:12];
    f7    = inst[31:25];
    immI  = {{20{inst[31]}}, inst[31:20]};
    immS  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    immU  = {inst[31:12], 12'h000};
    e        = '0;
    e.valid  = 1'b1;
    e.rd     = inst[11:7];
    e.pcadd4 = pc + 32'd4;
    e.op1    = rs1;
    e.op2    = rs2;
    legal    = 1'b1;
    we       = 1'b1;
    case (inst[6:0])
      7'h33: begin
        e.ctrl = ALU_TAB[f3];
        if (inst[30] && f3 == 3'd0) e.ctrl = 4'h1;
        if (inst[30] && f3 == 3'd5) e.ctrl = 4'h7;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.ctrl = ALU_TAB[f3];
        if (inst[30] && f3 == 3'd5) e.ctrl = 4'h7;
        e.op2 = immI;
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h37: begin e.ctrl = 4'hA; e.op1 = 32'd0; e.op2 = immU; end
      7'h17: begin e.ctrl = 4'h0; e.op1 = pc; e.op2 = immU; end
      7'h6F: begin e.ctrl = 4'hB; e.op1 = pc; end
      7'h67: begin e.ctrl = 4'hB; e.op2 = immI; legal = (f3 == 3'd0); end
      7'h03: begin e.ctrl = 4'h0; e.op2 = immI; end
      7'h23: begin e.ctrl = 4'h0; e.op2 = immS; we = 1'b0; end
      7'h63: begin
        e.ctrl = BR_TAB[f3];
        we     = 1'b0;
        legal  = (f3 != 3'd2) && (f3 != 3'd3);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.ill  = 1'b1;
      e.ctrl = 4'h0;
      e.op1  = 32'd0;
      e.op2  = 32'd0;
      we     = 1'b0;
    end
    e.we = we && (e.rd != 5'd0);
    return e;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".ex_valid"},    32'(bus.ex_valid),    32'(model.valid));
    compare({tag, ".ex_illegal"},  32'(bus.ex_illegal),  32'(model.ill));
    compare({tag, ".ex_reg_we"},   32'(bus.ex_reg_we),   32'(model.we));
    compare({tag, ".ex_alu_ctrl"}, 32'(bus.ex_alu_ctrl), 32'(model.ctrl));
    compare({tag, ".ex_rd"},       32'(bus.ex_rd),       32'(model.rd));
    compare({tag, ".ex_op1"},      bus.ex_op1,           model.op1);
    compare({tag, ".ex_op2"},      bus.ex_op2,           model.op2);
    compare({tag, ".ex_pcadd4"},   bus.ex_pcadd4,        model.pcadd4);
  endtask

  // One clock: drive at the falling edge, check ready, step the model, check EX.
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic fl, input logic er, input string tag);
    expect_t nxt;
    @(negedge clk);
    bus.id_valid    = v;
    bus.id_inst     = inst;
    bus.id_pc       = pc;
    bus.id_rs1_data = rs1;
    bus.id_rs2_data = rs2;
    bus.flush       = fl;
    bus.ex_ready    = er;
    #1;
    compare({tag, ".id_ready"}, 32'(bus.id_ready), 32'(fl | !model.valid | er));
    nxt = model;
    if (fl) begin
      nxt = '0;
    end else if (v && (!model.valid || er)) begin
      nxt = refDecode(inst, pc, rs1, rs2);
    end else if (er) begin
      nxt.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    model = nxt;
    checkOutput(tag);
  endtask

  task automatic addVec(input string name, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] ctrl,
                        input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd,
                        input logic we, input logic ill);
    vector_t t;
    t = '{name, inst, pc, rs1, rs2, ctrl, op1, op2, rd, we, ill};
    vecs.push_back(t);
  endtask

  initial begin
    addVec("sub",     32'h403100B3, 32'h00000100, 32'd10,        32'd3,  4'h1, 32'd10,        32'd3,        5'd1,  1'b1, 1'b0);
    addVec("srai",    32'h40435293, 32'h00000104, 32'h80000000,  32'd0,  4'h7, 32'h80000000,  32'h00000404, 5'd5,  1'b1, 1'b0);
    addVec("lui",     32'h123453B7, 32'h00000108, 32'hDEADBEEF,  32'd0,  4'hA, 32'd0,         32'h12345000, 5'd7,  1'b1, 1'b0);
    addVec("jalr",    32'h000280E7, 32'hFFFFFFFC, 32'h00002000,  32'h55, 4'hB, 32'h00002000,  32'd0,        5'd1,  1'b1, 1'b0);
    addVec("badopc",  32'h0000000B, 32'h00000200, 32'd1,         32'd2,  4'h0, 32'd0,         32'd0,        5'd0,  1'b0, 1'b1);
    addVec("addi_x0", 32'h00100013, 32'h00000204, 32'd5,         32'd9,  4'h0, 32'd5,         32'd1,        5'd0,  1'b0, 1'b0);
    addVec("auipc",   32'hFFFFF197, 32'h00001000, 32'd7,         32'd8,  4'h0, 32'h00001000,  32'hFFFFF000, 5'd3,  1'b1, 1'b0);
    addVec("sw",      32'hFE20AE23, 32'h00001004, 32'h00000400,  32'h99, 4'h0, 32'h00000400,  32'hFFFFFFFC, 5'd28, 1'b0, 1'b0);
    addVec("bltu",    32'h0020E063, 32'h00001008, 32'd3,         32'd4,  4'h4, 32'd3,         32'd4,        5'd0,  1'b0, 1'b0);
    addVec("br_f3_2", 32'h0020A063, 32'h0000100C, 32'd3,         32'd4,  4'h0, 32'd0,         32'd0,        5'd0,  1'b0, 1'b1);
    addVec("slli_f7", 32'h40121213, 32'h00001010, 32'd6,         32'd7,  4'h0, 32'd0,         32'd0,        5'd4,  1'b0, 1'b1);
    addVec("xor_f7",  32'h403140B3, 32'h00001014, 32'd6,         32'd7,  4'h0, 32'd0,         32'd0,        5'd1,  1'b0, 1'b1);
    addVec("sra",     32'h407352B3, 32'h00001018, 32'hF0000000,  32'd4,  4'h7, 32'hF0000000,  32'd4,        5'd5,  1'b1, 1'b0);
    addVec("jal",     32'h000000EF, 32'h00000300, 32'h11,        32'h22, 4'hB, 32'h00000300,  32'h22,       5'd1,  1'b1, 1'b0);
    addVec("lw",      32'h00812303, 32'h00000304, 32'h00001000,  32'd0,  4'h0, 32'h00001000,  32'd8,        5'd6,  1'b1, 1'b0);
    addVec("slti",    32'hFFF12093, 32'h00000308, 32'd1,         32'd0,  4'h3, 32'd1,         32'hFFFFFFFF, 5'd1,  1'b1, 1'b0);

    rst             = 1'b1;
    bus.id_valid    = 1'b0;
    bus.id_inst     = 32'd0;
    bus.id_pc       = 32'd0;
    bus.id_rs1_data = 32'd0;
    bus.id_rs2_data = 32'd0;
    bus.flush       = 1'b0;
    bus.ex_ready    = 1'b0;
    model           = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare("reset_release.id_ready", 32'(bus.id_ready), 32'd1);

    // Directed decode table, EX always ready.
    foreach (vecs[k]) begin
      applyStimulus(1'b1, vecs[k].inst, vecs[k].pc, vecs[k].rs1, vecs[k].rs2, 1'b0, 1'b1, vecs[k].name);
      compare({vecs[k].name, ".tbl_valid"},  32'(bus.ex_valid),    32'd1);
      compare({vecs[k].name, ".tbl_ctrl"},   32'(bus.ex_alu_ctrl), 32'(vecs[k].ctrl));
      compare({vecs[k].name, ".tbl_op1"},    bus.ex_op1,           vecs[k].op1);
      compare({vecs[k].name, ".tbl_op2"},    bus.ex_op2,           vecs[k].op2);
      compare({vecs[k].name, ".tbl_rd"},     32'(bus.ex_rd),       32'(vecs[k].rd));
      compare({vecs[k].name, ".tbl_we"},     32'(bus.ex_reg_we),   32'(vecs[k].we));
      compare({vecs[k].name, ".tbl_ill"},    32'(bus.ex_illegal),  32'(vecs[k].ill));
      compare({vecs[k].name, ".tbl_pcadd4"}, bus.ex_pcadd4,        vecs[k].pc + 32'd4);
    end

    // Back-pressure: the held beat must not move while EX stalls, then flush wins.
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, "drain");
    applyStimulus(1'b1, 32'h123453B7, 32'h00000400, 32'd0, 32'd0, 1'b0, 1'b0, "bp_load");
    compare("bp_load.valid", 32'(bus.ex_valid), 32'd1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h00100013, 32'h00000404, 32'd1, 32'd1, 1'b0, 1'b0, $sformatf("bp_hold%0d", c));
      compare($sformatf("bp_hold%0d.id_ready", c), 32'(bus.id_ready), 32'd0);
      compare($sformatf("bp_hold%0d.op2", c), bus.ex_op2, 32'h12345000);
      compare($sformatf("bp_hold%0d.ctrl", c), 32'(bus.ex_alu_ctrl), 32'hA);
    end
    applyStimulus(1'b1, 32'h403100B3, 32'h00000408, 32'd10, 32'd3, 1'b1, 1'b0, "flush");
    compare("flush.ex_valid_cleared", 32'(bus.ex_valid), 32'd0);

    // Asynchronous reset while a live instruction sits in the register.
    applyStimulus(1'b1, 32'h403100B3, 32'h00000500, 32'd10, 32'd3, 1'b0, 1'b0, "pre_rst");
    compare("pre_rst.valid", 32'(bus.ex_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    compare("async_rst.ex_valid", 32'(bus.ex_valid),    32'd0);
    compare("async_rst.ctrl",     32'(bus.ex_alu_ctrl), 32'd0);
    compare("async_rst.op1",      bus.ex_op1,           32'd0);
    compare("async_rst.op2",      bus.ex_op2,           32'd0);
    compare("async_rst.pcadd4",   bus.ex_pcadd4,        32'd0);
    compare("async_rst.rd",       32'(bus.ex_rd),       32'd0);
    compare("async_rst.reg_we",   32'(bus.ex_reg_we),   32'd0);
    model = '0;
    @(negedge clk);
    rst          = 1'b0;
    bus.id_valid = 1'b0;
    #1;
    compare("rst_release2.id_ready", 32'(bus.id_ready), 32'd1);

    // Random traffic, mostly well-formed opcodes, with stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        inst[6:0] = OPC_LIST[$urandom_range(0, 8)];
        if ($urandom_range(0, 3) != 0) inst[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      end
      applyStimulus($urandom_range(0, 9) < 8, inst, $urandom, $urandom, $urandom,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
